gpio_reg_bus_arbiter: RTL and testbench
=======================================

Name: gpio_reg_bus_arbiter

Overview:
- Owns the GPIO register bus (chip_sel/write_reg/read_reg/busaddress/busdata_in/busdata_out) that feeds the GPIO address decoder.
- Shares that bus between two requesters: the HPS host and an internal boot sequencer. The boot sequencer replays an (address, data) table from an external config ROM to preload DDR, open-drain and pin-mux registers after reset.
- Generates correctly timed strobes and captures read data.

Parameters:
- AddrWidth, 16, register byte-address width (bus carries [AddrWidth-1:2]).
- BusWidth, 32, data width.
- RomAddrWidth, 6, config ROM address width; table depth 2**RomAddrWidth.
- StrobeLen, 3, cycles a read/write strobe and its address/data are held.
- RdLatency, 4, cycles from strobe start to valid busdata_out.
- GapLen, 1, idle cycles forced between downstream transactions.

Ports:
- reg_clk  in  1  register clock.
- reset_in  in  1  asynchronous, active-high reset.
- host_cs  in  1  host request qualifier.
- host_write  in  1  host write request.
- host_read  in  1  host read request.
- host_address  in  AddrWidth-2  host word address.
- host_wdata  in  BusWidth  host write data.
- host_waitrequest  out  1  host request not yet accepted.
- host_rdata  out  BusWidth  host read data.
- host_rdatavalid  out  1  one-cycle pulse, host_rdata valid.
- boot_start  in  1  pulse; starts table replay.
- boot_busy  out  1  replay in progress.
- boot_done  out  1  sticky; replay finished.
- boot_overflow  out  1  sticky; table had no terminator.
- rom_addr  out  RomAddrWidth  config ROM address.
- rom_rd  out  1  ROM read enable.
- rom_data  in  AddrWidth-2+BusWidth  {word address, data}; 1-cycle read latency.
- chip_sel  out  1  downstream select.
- write_reg  out  1  downstream write strobe.
- read_reg  out  1  downstream read strobe.
- busaddress  out  AddrWidth-2  downstream word address.
- busdata_in  out  BusWidth  downstream write data.
- busdata_out  in  BusWidth  downstream read data.

Behaviour:
- Reset (async, immediate): all outputs 0 except host_waitrequest=1. FSM goes to IDLE; boot_done and boot_overflow are cleared. Reset mid-transaction drops the strobe at once; the aborted transaction is not replayed.
- FSM states: IDLE, ROM_RD, ROM_WAIT, STROBE, RD_WAIT, GAP.
- IDLE transitions:
  - boot pending (boot_busy=1) and boot holds the grant → ROM_RD.
  - Otherwise a host request (host_cs & (host_read|host_write)) → STROBE, with host_waitrequest low for exactly that cycle (accept).
- ROM_RD: rom_rd=1 for 1 cycle at rom_addr=entry index. ROM_WAIT samples rom_data.
  - Address field all-ones is the terminator: boot_busy←0, boot_done←1, → IDLE; no bus write is issued.
  - Otherwise → STROBE as a write.
- STROBE: chip_sel and write_reg (or read_reg) high with stable busaddress/busdata_in for StrobeLen cycles.
  - Write → GAP.
  - Read → RD_WAIT.
- RD_WAIT: capture busdata_out at cycle RdLatency counted from the first STROBE cycle. host_rdata is registered; host_rdatavalid pulses the next cycle. → GAP.
- GAP: all strobes low for GapLen cycles, address/data held. Then → IDLE.
- Arbitration while boot_busy uses alternating grant: after each boot write, a pending host request wins the next slot, then the grant returns to boot. With no host pending, boot continues back-to-back (ROM_RD follows GAP).
- Host read and write asserted together: the write is executed and the read is ignored.
- boot_start while boot_busy=1 is ignored. boot_start when idle:
  - sets boot_busy=1 the next cycle;
  - clears boot_done/boot_overflow;
  - sets entry index to 0.
- Entry index increments after each executed boot write. Wrap from 2**RomAddrWidth-1 without a terminator: boot_busy←0, boot_done←1, boot_overflow←1.
- Terminator at entry 0: boot_done asserts with zero bus writes; latency from boot_start to boot_done is 4 cycles.
- host_waitrequest stays high for a pending host request until accepted; host must hold request signals stable while waitrequest=1.
- busaddress/busdata_in hold their last values outside transactions (no glitching).

Decomposition:
- Shared package gpio_bus_pkg:
  - AddrWidth/BusWidth defaults;
  - ROM entry struct {addr, data};
  - TERMINATOR_ADDR='1;
  - state enum;
  - grant enum {GNT_HOST, GNT_BOOT}.
- One sub-module, gpio_boot_table_reader: owns the entry index, rom_rd/rom_addr, terminator/overflow detection and the boot_* flags. It presents a single request (valid, addr, data, ack) to the arbiter FSM.

Test Plan:
1. Reset mid-STROBE of a host write to 0x1100 → write_reg, chip_sel, read_reg drop the same cycle; host_waitrequest=1; no write occurs after reset release.
2. ROM {0x1100>>2, 0x00FFFFFF}, {0x1120>>2, 0x03020100}, terminator; boot_start → exactly 2 write strobes, each 3 cycles, separated by ≥1 idle cycle; boot_done=1, boot_overflow=0.
3. Host read 0x1124 with decoder model returning 0x07060504 at RdLatency → host_rdata=0x07060504, host_rdatavalid 1-cycle pulse at strobe start + 5.
4. Boot with 4 table writes plus host writes continuously pending → downstream order is boot, host, boot, host, boot, host, boot.
5. 64-entry ROM with no terminator → 64 writes, then boot_done=1, boot_overflow=1, boot_busy=0; a second boot_start clears both flags.
6. Terminator at entry 0; boot_start pulsed twice during replay → no bus strobes, boot_done 4 cycles after the first pulse, second pulse ignored.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// rtl/gpio_bus_pkg.sv - shared types and constants for the GPIO register bus arbiter
package gpio_bus_pkg;

  localparam int ADDR_WIDTH_DEF      = 16;
  localparam int BUS_WIDTH_DEF       = 32;
  localparam int WORD_ADDR_WIDTH_DEF = ADDR_WIDTH_DEF - 2;

  // One config ROM row: {word address, write data}
  typedef struct packed {
    logic [WORD_ADDR_WIDTH_DEF-1:0] addr;
    logic [BUS_WIDTH_DEF-1:0]       data;
  } rom_entry_t;

  // An all-ones address field ends the boot table
  localparam logic [WORD_ADDR_WIDTH_DEF-1:0] TERMINATOR_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    ROM_RD,
    ROM_WAIT,
    STROBE,
    RD_WAIT,
    GAP
  } state_e;

  typedef enum logic {
    GNT_HOST,
    GNT_BOOT
  } grant_e;

endpackage

// File: rtl/gpio_boot_table_reader.sv
// rtl/gpio_boot_table_reader.sv - walks the config ROM and presents boot writes to the arbiter
module gpio_boot_table_reader
  import gpio_bus_pkg::*;
#(
  parameter int AddrWidth    = ADDR_WIDTH_DEF,
  parameter int BusWidth     = BUS_WIDTH_DEF,
  parameter int RomAddrWidth = 6
) (
  input  logic                            reg_clk,
  input  logic                            reset_in,
  input  logic                            boot_start_i,
  input  logic                            fetch_i,
  input  logic                            ack_i,
  input  logic [AddrWidth-2+BusWidth-1:0] rom_data_i,
  output logic                            rom_rd_o,
  output logic [RomAddrWidth-1:0]         rom_addr_o,
  output logic                            req_valid_o,
  output logic [AddrWidth-3:0]            req_addr_o,
  output logic [BusWidth-1:0]             req_data_o,
  output logic                            boot_busy_o,
  output logic                            boot_done_o,
  output logic                            boot_overflow_o
);

  logic [RomAddrWidth-1:0] index_q;
  logic                    pending_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    overflow_q;
  logic                    term_hit;

  // ROM data is valid in the cycle after the read strobe (pending_q)
  assign req_addr_o  = rom_data_i[AddrWidth-2+BusWidth-1:BusWidth];
  assign req_data_o  = rom_data_i[BusWidth-1:0];
  assign term_hit    = pending_q & (&req_addr_o);
  assign req_valid_o = pending_q & ~(&req_addr_o);

  assign rom_rd_o        = fetch_i;
  assign rom_addr_o      = index_q;
  assign boot_busy_o     = busy_q;
  assign boot_done_o     = done_q;
  assign boot_overflow_o = overflow_q;

  // Entry index and sticky replay status; start is ignored while a replay runs
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      index_q    <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= fetch_i;
      if (boot_start_i && !busy_q) begin
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
        index_q    <= '0;
      end else if (term_hit) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else if (ack_i) begin
        index_q <= index_q + 1'b1;
        if (&index_q) begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_reg_bus_arbiter.sv
// rtl/gpio_reg_bus_arbiter.sv - shares the GPIO register bus between host and boot sequencer
module gpio_reg_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int AddrWidth    = ADDR_WIDTH_DEF,
  parameter int BusWidth     = BUS_WIDTH_DEF,
  parameter int RomAddrWidth = 6,
  parameter int StrobeLen    = 3,
  parameter int RdLatency    = 4,
  parameter int GapLen       = 1
) (
  input  logic                            reg_clk,
  input  logic                            reset_in,
  input  logic                            host_cs,
  input  logic                            host_write,
  input  logic                            host_read,
  input  logic [AddrWidth-3:0]            host_address,
  input  logic [BusWidth-1:0]             host_wdata,
  output logic                            host_waitrequest,
  output logic [BusWidth-1:0]             host_rdata,
  output logic                            host_rdatavalid,
  input  logic                            boot_start,
  output logic                            boot_busy,
  output logic                            boot_done,
  output logic                            boot_overflow,
  output logic [RomAddrWidth-1:0]         rom_addr,
  output logic                            rom_rd,
  input  logic [AddrWidth-2+BusWidth-1:0] rom_data,
  output logic                            chip_sel,
  output logic                            write_reg,
  output logic                            read_reg,
  output logic [AddrWidth-3:0]            busaddress,
  output logic [BusWidth-1:0]             busdata_in,
  input  logic [BusWidth-1:0]             busdata_out
);

  localparam logic [7:0] STROBE_LAST = 8'(StrobeLen - 1);
  localparam logic [7:0] RD_CAPTURE  = 8'(RdLatency);
  localparam logic [7:0] GAP_LAST    = 8'(GapLen - 1);

  state_e               state_q;
  grant_e               grant_q;
  logic [7:0]           cnt_q;
  logic                 is_write_q;
  logic                 fetch_q;
  logic                 chip_sel_q;
  logic                 write_reg_q;
  logic                 read_reg_q;
  logic [AddrWidth-3:0] busaddress_q;
  logic [BusWidth-1:0]  busdata_in_q;
  logic [BusWidth-1:0]  host_rdata_q;
  logic                 host_rdatavalid_q;

  logic                 host_req;
  logic                 boot_sel;
  logic                 host_accept;
  logic                 boot_ack;
  logic                 req_valid;
  logic [AddrWidth-3:0] req_addr;
  logic [BusWidth-1:0]  req_data;

  // Boot owns the next slot unless it just wrote and the host is waiting
  assign host_req    = host_cs & (host_read | host_write);
  assign boot_sel    = boot_busy & ((grant_q == GNT_BOOT) | ~host_req);
  assign host_accept = (state_q == IDLE) & host_req & ~boot_sel & ~reset_in;
  assign boot_ack    = (state_q == ROM_WAIT) & req_valid;

  assign host_waitrequest = ~host_accept;
  assign host_rdata       = host_rdata_q;
  assign host_rdatavalid  = host_rdatavalid_q;
  assign chip_sel         = chip_sel_q;
  assign write_reg        = write_reg_q;
  assign read_reg         = read_reg_q;
  assign busaddress       = busaddress_q;
  assign busdata_in       = busdata_in_q;

  gpio_boot_table_reader #(
    .AddrWidth    (AddrWidth),
    .BusWidth     (BusWidth),
    .RomAddrWidth (RomAddrWidth)
  ) u_reader (
    .reg_clk         (reg_clk),
    .reset_in        (reset_in),
    .boot_start_i    (boot_start),
    .fetch_i         (fetch_q),
    .ack_i           (boot_ack),
    .rom_data_i      (rom_data),
    .rom_rd_o        (rom_rd),
    .rom_addr_o      (rom_addr),
    .req_valid_o     (req_valid),
    .req_addr_o      (req_addr),
    .req_data_o      (req_data),
    .boot_busy_o     (boot_busy),
    .boot_done_o     (boot_done),
    .boot_overflow_o (boot_overflow)
  );

  // Bus transaction FSM; strobes, address/data and read capture are all registered
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      state_q           <= IDLE;
      grant_q           <= GNT_BOOT;
      cnt_q             <= '0;
      is_write_q        <= 1'b0;
      fetch_q           <= 1'b0;
      chip_sel_q        <= 1'b0;
      write_reg_q       <= 1'b0;
      read_reg_q        <= 1'b0;
      busaddress_q      <= '0;
      busdata_in_q      <= '0;
      host_rdata_q      <= '0;
      host_rdatavalid_q <= 1'b0;
    end else begin
      fetch_q           <= 1'b0;
      host_rdatavalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (boot_sel) begin
            state_q <= ROM_RD;
            fetch_q <= 1'b1;
          end else if (host_req) begin
            // A simultaneous read and write executes as a write
            state_q      <= STROBE;
            cnt_q        <= '0;
            is_write_q   <= host_write;
            chip_sel_q   <= 1'b1;
            write_reg_q  <= host_write;
            read_reg_q   <= ~host_write;
            busaddress_q <= host_address;
            if (host_write) busdata_in_q <= host_wdata;
            grant_q      <= GNT_BOOT;
          end
        end
        ROM_RD: state_q <= ROM_WAIT;
        ROM_WAIT: begin
          if (req_valid) begin
            state_q      <= STROBE;
            cnt_q        <= '0;
            is_write_q   <= 1'b1;
            chip_sel_q   <= 1'b1;
            write_reg_q  <= 1'b1;
            read_reg_q   <= 1'b0;
            busaddress_q <= req_addr;
            busdata_in_q <= req_data;
            grant_q      <= GNT_HOST;
          end else begin
            state_q <= IDLE;
          end
        end
        STROBE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == STROBE_LAST) begin
            chip_sel_q  <= 1'b0;
            write_reg_q <= 1'b0;
            read_reg_q  <= 1'b0;
            if (is_write_q) begin
              state_q <= GAP;
              cnt_q   <= '0;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // cnt_q keeps counting from the first strobe cycle
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == RD_CAPTURE) begin
            host_rdata_q      <= busdata_out;
            host_rdatavalid_q <= 1'b1;
            state_q           <= GAP;
            cnt_q             <= '0;
          end
        end
        GAP: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (boot_sel) begin
              state_q <= ROM_RD;
              fetch_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_reg_bus_arbiter.sv
// tb/tb_gpio_reg_bus_arbiter.sv - directed self-checking bench for gpio_reg_bus_arbiter
module tb_gpio_reg_bus_arbiter;
  import gpio_bus_pkg::*;

  localparam int AW = ADDR_WIDTH_DEF - 2;
  localparam int BW = BUS_WIDTH_DEF;

  logic          reg_clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          host_cs = 1'b0, host_write = 1'b0, host_read = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic [BW-1:0] host_wdata = '0;
  logic          host_waitrequest, host_rdatavalid;
  logic [BW-1:0] host_rdata;
  logic          boot_start = 1'b0;
  logic          boot_busy, boot_done, boot_overflow;
  logic [5:0]    rom_addr;
  logic          rom_rd;
  logic [AW+BW-1:0] rom_data = '0;
  logic          chip_sel, write_reg, read_reg;
  logic [AW-1:0] busaddress;
  logic [BW-1:0] busdata_in, busdata_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 reg_clk = ~reg_clk;
  always @(posedge reg_clk) cyc <= cyc + 1;

  gpio_reg_bus_arbiter dut (
    .reg_clk(reg_clk), .reset_in(reset_in),
    .host_cs(host_cs), .host_write(host_write), .host_read(host_read),
    .host_address(host_address), .host_wdata(host_wdata),
    .host_waitrequest(host_waitrequest), .host_rdata(host_rdata),
    .host_rdatavalid(host_rdatavalid),
    .boot_start(boot_start), .boot_busy(boot_busy), .boot_done(boot_done),
    .boot_overflow(boot_overflow),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .chip_sel(chip_sel), .write_reg(write_reg), .read_reg(read_reg),
    .busaddress(busaddress), .busdata_in(busdata_in), .busdata_out(busdata_out)
  );

  // Config ROM with one cycle of read latency
  rom_entry_t rom_mem [64];
  always @(posedge reg_clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

  // Decoder model: read data is only valid RdLatency cycles after strobe start
  logic read_reg_d = 1'b0;
  int   rd_age = 0;
  always @(posedge reg_clk) begin
    read_reg_d <= read_reg;
    if (read_reg && !read_reg_d) rd_age <= 1;
    else if (rd_age > 0) rd_age <= rd_age + 1;
  end
  assign busdata_out = (rd_age == 4) ? 32'h0706_0504 : 32'hDEAD_BEEF;

  // Bus monitor: one log entry per chip_sel burst
  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    int            len;
    int            gap;
    int            start;
    bit            wr;
    bit            stable;
  } xact_t;

  xact_t         xlog[$];
  xact_t         cur;
  int            cs_len = 0;
  int            idle_cnt = 999;
  int            rv_cyc[$];
  logic [BW-1:0] rv_data[$];

  always @(negedge reg_clk) begin
    if (chip_sel) begin
      if (cs_len == 0) begin
        cur.addr = busaddress; cur.data = busdata_in; cur.wr = write_reg;
        cur.gap = idle_cnt; cur.start = cyc; cur.stable = 1'b1;
      end else if (busaddress !== cur.addr || busdata_in !== cur.data || write_reg !== cur.wr) begin
        cur.stable = 1'b0;
      end
      if (read_reg === write_reg) cur.stable = 1'b0;
      cs_len++;
    end else begin
      if (cs_len != 0) begin
        cur.len = cs_len;
        xlog.push_back(cur);
        cs_len = 0;
        idle_cnt = 1;
      end else if (idle_cnt < 999) begin
        idle_cnt++;
      end
    end
    if (host_rdatavalid) begin
      rv_cyc.push_back(cyc);
      rv_data.push_back(host_rdata);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    xlog.delete();
    rv_cyc.delete();
    rv_data.delete();
  endtask

  task automatic host_xact(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d);
    int t = 0;
    @(negedge reg_clk);
    host_cs = 1'b1; host_write = wr; host_read = ~wr; host_address = a; host_wdata = d;
    #1;
    while (host_waitrequest === 1'b1 && t < 200) begin
      @(negedge reg_clk); #1; t++;
    end
    check_eq("host_accept_timeout", 64'(t >= 200), 64'(0));
    @(posedge reg_clk); #1;
    host_cs = 1'b0; host_write = 1'b0; host_read = 1'b0;
  endtask

  task automatic boot_pulse();
    @(negedge reg_clk); boot_start = 1'b1;
    @(negedge reg_clk); boot_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int t = 0;
    while (boot_done !== 1'b1 && t < limit) begin
      @(negedge reg_clk); t++;
    end
    check_eq(tag, 64'(t >= limit), 64'(0));
  endtask

  logic [AW-1:0] exp4 [7];
  int bad;
  int c0;
  int t;

  initial begin
    foreach (rom_mem[i]) rom_mem[i] = '{addr: '0, data: '0};
    exp4 = '{14'h500, 14'h600, 14'h501, 14'h600, 14'h502, 14'h600, 14'h503};

    // Reset state
    repeat (3) @(negedge reg_clk);
    check_eq("rst_strobes", 64'({chip_sel, write_reg, read_reg, rom_rd, host_rdatavalid}), 64'(0));
    check_eq("rst_waitreq", 64'(host_waitrequest), 64'(1));
    check_eq("rst_boot_flags", 64'({boot_busy, boot_done, boot_overflow}), 64'(0));
    check_eq("rst_bus", 64'({busaddress, busdata_in}), 64'(0));
    reset_in = 1'b0;

    // 1: reset during a host write strobe
    host_xact(1'b1, 14'h440, 32'hA5A5_5A5A);
    check_eq("t1_in_strobe", 64'({chip_sel, write_reg}), 64'(2'b11));
    #3 reset_in = 1'b1;
    #1;
    check_eq("t1_strobes_drop", 64'({chip_sel, write_reg, read_reg}), 64'(0));
    check_eq("t1_waitreq", 64'(host_waitrequest), 64'(1));
    check_eq("t1_bus_cleared", 64'(busaddress), 64'(0));
    repeat (2) @(negedge reg_clk);
    reset_in = 1'b0;
    @(negedge reg_clk);
    clear_logs();
    repeat (20) @(negedge reg_clk);
    check_eq("t1_no_replay", 64'(xlog.size()), 64'(0));

    // 2: two-entry boot table with terminator
    rom_mem[0] = '{addr: 14'h440, data: 32'h00FF_FFFF};
    rom_mem[1] = '{addr: 14'h448, data: 32'h0302_0100};
    rom_mem[2] = '{addr: TERMINATOR_ADDR, data: 32'h0};
    clear_logs();
    boot_pulse();
    wait_done("t2_done_timeout", 200);
    repeat (5) @(negedge reg_clk);
    check_eq("t2_count", 64'(xlog.size()), 64'(2));
    if (xlog.size() == 2) begin
      check_eq("t2_w0", {xlog[0].addr, xlog[0].data}, {14'h440, 32'h00FF_FFFF});
      check_eq("t2_w1", {xlog[1].addr, xlog[1].data}, {14'h448, 32'h0302_0100});
      check_eq("t2_len", 64'({xlog[0].len[7:0], xlog[1].len[7:0]}), 64'(16'h0303));
      check_eq("t2_wr_stable", 64'({xlog[0].wr, xlog[0].stable, xlog[1].wr, xlog[1].stable}), 64'(4'hF));
      check_eq("t2_gap", 64'(xlog[1].gap >= 1), 64'(1));
    end
    check_eq("t2_flags", 64'({boot_busy, boot_done, boot_overflow}), 64'(3'b010));

    // 3: host read with late decoder data
    clear_logs();
    host_xact(1'b0, 14'h449, 32'h0);
    repeat (15) @(negedge reg_clk);
    check_eq("t3_count", 64'(xlog.size()), 64'(1));
    check_eq("t3_rv_count", 64'(rv_cyc.size()), 64'(1));
    if (xlog.size() == 1 && rv_cyc.size() == 1) begin
      check_eq("t3_read", 64'({xlog[0].wr, xlog[0].addr, xlog[0].len[7:0]}), {1'b0, 14'h449, 8'd3});
      check_eq("t3_rdata", 64'(rv_data[0]), 64'(32'h0706_0504));
      check_eq("t3_rv_cycle", 64'(rv_cyc[0] - xlog[0].start), 64'(5));
    end

    // 4: alternating grant with host always pending
    for (int i = 0; i < 4; i++) rom_mem[i] = '{addr: 14'h500 + 14'(i), data: 32'hB000_0000 + 32'(i)};
    rom_mem[4] = '{addr: TERMINATOR_ADDR, data: 32'h0};
    clear_logs();
    boot_pulse();
    host_cs = 1'b1; host_write = 1'b1; host_read = 1'b0;
    host_address = 14'h600; host_wdata = 32'hCAFE_0000;
    wait_done("t4_done_timeout", 300);
    @(negedge reg_clk);
    host_cs = 1'b0; host_write = 1'b0;
    repeat (20) @(negedge reg_clk);
    check_eq("t4_count_ge7", 64'(xlog.size() >= 7), 64'(1));
    for (int i = 0; i < 7; i++)
      if (i < xlog.size()) check_eq($sformatf("t4_order%0d", i), 64'({xlog[i].wr, xlog[i].addr}), 64'({1'b1, exp4[i]}));
    if (xlog.size() >= 1) check_eq("t4_boot_data", 64'(xlog[0].data), 64'(32'hB000_0000));

    // 5: full table without terminator
    for (int i = 0; i < 64; i++) rom_mem[i] = '{addr: 14'h100 + 14'(i), data: 32'h1000_0000 + 32'(i)};
    clear_logs();
    boot_pulse();
    wait_done("t5_done_timeout", 1000);
    repeat (5) @(negedge reg_clk);
    check_eq("t5_count", 64'(xlog.size()), 64'(64));
    bad = 0;
    foreach (xlog[i]) if (xlog[i].len != 3 || !xlog[i].wr || !xlog[i].stable || xlog[i].addr != 14'h100 + 14'(i)) bad++;
    check_eq("t5_bad_writes", 64'(bad), 64'(0));
    check_eq("t5_flags", 64'({boot_busy, boot_done, boot_overflow}), 64'(3'b011));
    rom_mem[0] = '{addr: TERMINATOR_ADDR, data: 32'h0};
    boot_pulse();
    check_eq("t5_restart_flags", 64'({boot_busy, boot_done, boot_overflow}), 64'(3'b100));
    wait_done("t5_restart_timeout", 50);
    check_eq("t5_restart_ovf", 64'(boot_overflow), 64'(0));

    // 6: terminator at entry 0, second start pulse during replay
    repeat (5) @(negedge reg_clk);
    clear_logs();
    @(negedge reg_clk); boot_start = 1'b1; c0 = cyc;
    @(negedge reg_clk); boot_start = 1'b0;
    check_eq("t6_done_cleared", 64'(boot_done), 64'(0));
    @(negedge reg_clk); boot_start = 1'b1;
    @(negedge reg_clk); boot_start = 1'b0;
    t = 0;
    while (boot_done !== 1'b1 && t < 50) begin @(negedge reg_clk); t++; end
    check_eq("t6_done_latency", 64'(cyc - c0), 64'(4));
    repeat (10) @(negedge reg_clk);
    check_eq("t6_no_strobes", 64'(xlog.size()), 64'(0));
    check_eq("t6_second_ignored", 64'({boot_busy, boot_done}), 64'(2'b01));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
